// File: rtl/cordic_fp_pkg.sv
// Shared FP32 field constants and the stage-1 aligned-operand record.
package cordic_fp_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  // Width of the aligned magnitude carried between stages; results wider than
  // ALIGN_W-1 integer bits are clamped to all-ones, so OUT_WIDTH must stay below it.
  localparam int ALIGN_W = 64;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic                 sign;
    fp_class_e            cls;
    logic [ALIGN_W-1:0]   mag;     // integer part of |value| * 2^FRACTIONAL_BITS
    logic                 guard;   // weight 1/2
    logic                 rnd;     // weight 1/4
    logic                 sticky;  // OR of everything below 1/4
  } fp_align_t;

endpackage

// File: rtl/fixed_round_sat.sv
// Stage-2 datapath: rounds the aligned magnitude, applies the sign and clamps
// to the signed OUT_WIDTH range. Purely combinational; the top registers it.
module fixed_round_sat
  import cordic_fp_pkg::*;
#(
  parameter int OUT_WIDTH  = 32,
  parameter int ROUND_MODE = 1
) (
  input  fp_align_t                   align,
  output logic signed [OUT_WIDTH-1:0] data,
  output logic                        ovf,
  output logic                        nan
);

  localparam logic [ALIGN_W:0] ONE     = {{ALIGN_W{1'b0}}, 1'b1};
  localparam logic [ALIGN_W:0] NEG_LIM = ONE << (OUT_WIDTH - 1);
  localparam logic [ALIGN_W:0] POS_LIM = NEG_LIM - ONE;
  localparam logic signed [OUT_WIDTH-1:0] MAX_VAL = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MIN_VAL = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Round-to-nearest-even on the magnitude (sign-symmetric), or plain truncation.
  // One extra bit keeps a carry out of an all-ones clamped magnitude.
  function automatic logic [ALIGN_W:0] round_mag(input fp_align_t a);
    logic inc;
    inc = (ROUND_MODE == 1) && a.guard && (a.rnd || a.sticky || a.mag[0]);
    return {1'b0, a.mag} + {{ALIGN_W{1'b0}}, inc};
  endfunction

  // Negative side admits one more code (exact -2^(OUT_WIDTH-1) is not overflow).
  function automatic logic sat_ovf(input logic sign, input logic [ALIGN_W:0] mag);
    return sign ? (mag > NEG_LIM) : (mag > POS_LIM);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat_val(input logic sign,
                                                          input logic [ALIGN_W:0] mag);
    logic [OUT_WIDTH-1:0] low;
    low = mag[OUT_WIDTH-1:0];
    if (sat_ovf(sign, mag)) return sign ? MIN_VAL : MAX_VAL;
    return sign ? $signed(~low + 1'b1) : $signed(low);
  endfunction

  logic [ALIGN_W:0] mag_r;

  // Select the result per operand class; zero/denormal falls through to the defaults.
  always_comb begin
    mag_r = round_mag(align);
    data  = '0;
    ovf   = 1'b0;
    nan   = 1'b0;
    unique case (align.cls)
      NORM: begin
        data = sat_val(align.sign, mag_r);
        ovf  = sat_ovf(align.sign, mag_r);
      end
      INF: begin
        data = align.sign ? MIN_VAL : MAX_VAL;
        ovf  = 1'b1;
      end
      NAN:     nan = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/float_unpack_pipe.sv
// FP32 to signed fixed-point converter, two-stage valid/ready pipeline:
// stage 1 decodes and aligns, stage 2 (fixed_round_sat) rounds and saturates.
module float_unpack_pipe
  import cordic_fp_pkg::*;
#(
  parameter int FRACTIONAL_BITS = 31,
  parameter int OUT_WIDTH       = 32,
  parameter int ROUND_MODE      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 out_nan
);

  localparam int SIG_W   = FP32_MAN_W + 1;           // significand with hidden one
  localparam int LOW_W   = SIG_W + 2;                // room for every sig bit plus guard and round
  localparam int EXT_W   = SIG_W + LOW_W;
  localparam int MAX_LSH = ALIGN_W - SIG_W - 1;      // largest left shift that fits ALIGN_W-1 bits
  localparam int SH_OFS  = FRACTIONAL_BITS - FP32_BIAS - FP32_MAN_W;

  logic [FP32_EXP_W-1:0] exp_p0;
  logic [FP32_MAN_W-1:0] man_p0;
  logic [SIG_W-1:0]      sig_p0;
  logic [EXT_W-1:0]      ext_p0;
  int                    lsh_p0;
  int                    rsh_p0;
  fp_align_t             align_p0;

  logic                  vld_p1;
  fp_align_t             align_p1;
  logic                  vld_p2;
  logic signed [OUT_WIDTH-1:0] data_p2;
  logic                  ovf_p2;
  logic                  nan_p2;

  logic                  s1_advance;
  logic signed [OUT_WIDTH-1:0] rs_data;
  logic                  rs_ovf;
  logic                  rs_nan;

  // Decode, classify and align the operand. Right shifts past the guard/round
  // window leave only sticky set instead of wrapping the shift amount.
  always_comb begin
    exp_p0         = in_data[FP32_MAN_W +: FP32_EXP_W];
    man_p0         = in_data[FP32_MAN_W-1:0];
    sig_p0         = {1'b1, man_p0};
    lsh_p0         = int'(exp_p0) + SH_OFS;
    rsh_p0         = -lsh_p0;
    ext_p0         = '0;
    align_p0       = '0;
    align_p0.sign  = in_data[31];
    if (exp_p0 == '0) begin
      align_p0.cls = ZERO;
    end else if (exp_p0 == '1) begin
      align_p0.cls = (man_p0 != '0) ? NAN : INF;
    end else begin
      align_p0.cls = NORM;
      if (lsh_p0 > MAX_LSH) begin
        align_p0.mag = '1;
      end else if (lsh_p0 >= 0) begin
        align_p0.mag = ALIGN_W'(sig_p0) << lsh_p0;
      end else if (rsh_p0 > LOW_W) begin
        align_p0.sticky = 1'b1;
      end else begin
        ext_p0          = {sig_p0, {LOW_W{1'b0}}} >> rsh_p0;
        align_p0.mag    = ALIGN_W'(ext_p0[EXT_W-1:LOW_W]);
        align_p0.guard  = ext_p0[LOW_W-1];
        align_p0.rnd    = ext_p0[LOW_W-2];
        align_p0.sticky = |ext_p0[LOW_W-3:0];
      end
    end
  end

  assign s1_advance = !vld_p2 || out_ready;
  assign in_ready   = !vld_p1 || s1_advance;

  // ---- stage 1 / stage 2 boundary: valid bits, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready)   vld_p1 <= in_valid;
      if (s1_advance) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1 register: aligned operand, captured on input transfer
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) align_p1 <= align_p0;
  end

  fixed_round_sat #(
    .OUT_WIDTH  (OUT_WIDTH),
    .ROUND_MODE (ROUND_MODE)
  ) u_round_sat (
    .align (align_p1),
    .data  (rs_data),
    .ovf   (rs_ovf),
    .nan   (rs_nan)
  );

  // ---- stage 2 register: result, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p2 <= '0;
      ovf_p2  <= 1'b0;
      nan_p2  <= 1'b0;
    end else if (vld_p1 && s1_advance) begin
      data_p2 <= rs_data;
      ovf_p2  <= rs_ovf;
      nan_p2  <= rs_nan;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_ovf   = ovf_p2;
  assign out_nan   = nan_p2;

endmodule
